// File: rtl/iic_txn_ctrl.sv
// I2C slave write-transaction controller: decodes address/pointer/data bytes into register writes.
// Optional idle-bus watchdog enabled by defining IIC_TXN_TIMEOUT_EN.
module iic_txn_ctrl #(
    parameter logic [6:0] DEV_ADDR       = 7'h50,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IIC_START,
    input  logic       IIC_END,
    input  logic [7:0] IIC_DATA,
    input  logic       IIC_DATA_VLD,
    output logic       WR_REQ,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    input  logic       WR_ACK,
    output logic       ADDR_MATCH,
    output logic       TXN_BUSY,
    output logic       TXN_DONE,
    output logic       TXN_ERR,
    output logic [7:0] BYTE_CNT
);

    typedef enum logic [2:0] {IDLE, ADDR, REG, DATA, IGNORE} state_t;

    state_t     state, state_nx;
    logic       match_nx, done_nx, err_nx;
    logic       enq, ld_ptr, wd_hit;
    logic [7:0] ptr;
    logic       out_vld, pend_vld;
    logic [7:0] out_addr, out_data, pend_addr, pend_data;
    logic       addr_hit, both_full, ack;

    assign addr_hit  = (IIC_DATA[7:1] == DEV_ADDR) && !IIC_DATA[0];
    assign both_full = out_vld && pend_vld;
    assign ack       = WR_ACK && out_vld;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        match_nx = ADDR_MATCH;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        enq      = 1'b0;
        ld_ptr   = 1'b0;
        if (IIC_START) begin
            state_nx = ADDR;
            match_nx = 1'b0;
        end else if (IIC_END) begin
            state_nx = IDLE;
            match_nx = 1'b0;
            done_nx  = ADDR_MATCH;
        end else if (wd_hit) begin
            state_nx = IDLE;
            match_nx = 1'b0;
            err_nx   = 1'b1;
        end else if (IIC_DATA_VLD) begin
            case (state)
                ADDR: begin
                    if (addr_hit) begin
                        state_nx = REG;
                        match_nx = 1'b1;
                    end else begin
                        state_nx = IGNORE;
                    end
                end
                REG: begin
                    ld_ptr   = 1'b1;
                    state_nx = DATA;
                end
                DATA: begin
                    // No room even if the output retires this cycle: drop and abort
                    if (both_full) begin
                        err_nx   = 1'b1;
                        state_nx = IGNORE;
                    end else begin
                        enq = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ADDR_MATCH <= 1'b0;
            TXN_DONE   <= 1'b0;
            TXN_ERR    <= 1'b0;
            BYTE_CNT   <= 8'h00;
            ptr        <= 8'h00;
        end else begin
            ADDR_MATCH <= match_nx;
            TXN_DONE   <= done_nx;
            TXN_ERR    <= err_nx;
            if (IIC_START)
                BYTE_CNT <= 8'h00;
            else if (enq && BYTE_CNT != 8'hFF)
                BYTE_CNT <= BYTE_CNT + 8'd1;
            if (ld_ptr)
                ptr <= IIC_DATA;
            else if (enq)
                ptr <= ptr + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_addr  <= 8'h00;
            out_data  <= 8'h00;
            pend_vld  <= 1'b0;
            pend_addr <= 8'h00;
            pend_data <= 8'h00;
        end else if (ack && pend_vld) begin
            out_addr <= pend_addr;
            out_data <= pend_data;
            pend_vld <= 1'b0;
        end else if (ack || !out_vld) begin
            // Output is free this cycle: a new byte goes straight to it
            out_vld <= enq;
            if (enq) begin
                out_addr <= ptr;
                out_data <= IIC_DATA;
            end
        end else if (enq) begin
            pend_vld  <= 1'b1;
            pend_addr <= ptr;
            pend_data <= IIC_DATA;
        end
    end

    assign WR_REQ   = out_vld;
    assign WR_ADDR  = out_addr;
    assign WR_DATA  = out_data;
    assign TXN_BUSY = (state != IDLE) || out_vld || pend_vld;

`ifdef IIC_TXN_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_run;

    assign wd_run = (state == ADDR) || (state == REG) || (state == DATA);
    assign wd_hit = wd_run && (wd_cnt == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= 32'd0;
        else if (IIC_START || IIC_END || IIC_DATA_VLD || !wd_run || wd_hit)
            wd_cnt <= 32'd0;
        else
            wd_cnt <= wd_cnt + 32'd1;
    end
`else
    logic unused_cfg;

    assign wd_hit     = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_iic_txn_ctrl.sv
// Directed self-checking bench for iic_txn_ctrl.
// Timeout scenario runs only when IIC_TXN_TIMEOUT_EN is defined.
module tb_iic_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       IIC_START = 1'b0;
    logic       IIC_END = 1'b0;
    logic [7:0] IIC_DATA = 8'h00;
    logic       IIC_DATA_VLD = 1'b0;
    logic       WR_REQ;
    logic [7:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       WR_ACK = 1'b0;
    logic       ADDR_MATCH;
    logic       TXN_BUSY;
    logic       TXN_DONE;
    logic       TXN_ERR;
    logic [7:0] BYTE_CNT;

    int checks = 0;
    int errors = 0;

    logic       auto_ack = 1'b0;
    int         wr_n = 0;
    int         done_n = 0;
    int         err_n = 0;
    logic [7:0] wr_a [0:1023];
    logic [7:0] wr_d [0:1023];

    always #5 clk = ~clk;

    iic_txn_ctrl #(
        .DEV_ADDR      (7'h50),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IIC_START   (IIC_START),
        .IIC_END     (IIC_END),
        .IIC_DATA    (IIC_DATA),
        .IIC_DATA_VLD(IIC_DATA_VLD),
        .WR_REQ      (WR_REQ),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .WR_ACK      (WR_ACK),
        .ADDR_MATCH  (ADDR_MATCH),
        .TXN_BUSY    (TXN_BUSY),
        .TXN_DONE    (TXN_DONE),
        .TXN_ERR     (TXN_ERR),
        .BYTE_CNT    (BYTE_CNT)
    );

    // Register bank model: acknowledge one cycle after each request
    initial forever begin
        @(posedge clk);
        #1;
        WR_ACK = auto_ack && WR_REQ && !WR_ACK;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (WR_REQ && WR_ACK && wr_n < 1024) begin
                wr_a[wr_n] = WR_ADDR;
                wr_d[wr_n] = WR_DATA;
                wr_n++;
            end
            if (TXN_DONE) done_n++;
            if (TXN_ERR) err_n++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        IIC_START = 1'b1;
        tick();
        IIC_START = 1'b0;
    endtask

    task automatic do_end();
        IIC_END = 1'b1;
        tick();
        IIC_END = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        IIC_DATA     = b;
        IIC_DATA_VLD = 1'b1;
        tick();
        IIC_DATA_VLD = 1'b0;
    endtask

    task automatic test_reset();
        logic [28:0] o;
        rst = 1'b1;
        tick(2);
        o = {WR_REQ, WR_ADDR, WR_DATA, ADDR_MATCH, TXN_BUSY,
             TXN_DONE, TXN_ERR, BYTE_CNT};
        checks++;
        if (o !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_write();
        int w0 = wr_n;
        int d0 = done_n;
        auto_ack = 1'b1;
        do_start();
        checks++;
        if ({TXN_BUSY, ADDR_MATCH} !== 2'b10) begin
            errors++;
            $display("FAIL basic_start busy/match got %b want 10",
                     {TXN_BUSY, ADDR_MATCH});
        end
        send(8'hA0);
        checks++;
        if (ADDR_MATCH !== 1'b1) begin
            errors++;
            $display("FAIL basic_match got %b want 1", ADDR_MATCH);
        end
        send(8'h10);
        send(8'h11);
        checks++;
        if ({WR_REQ, WR_ADDR, WR_DATA} !== {1'b1, 8'h10, 8'h11}) begin
            errors++;
            $display("FAIL basic_first_req got %b %h %h want 1 10 11",
                     WR_REQ, WR_ADDR, WR_DATA);
        end
        send(8'h22);
        do_end();
        checks++;
        if ({TXN_DONE, ADDR_MATCH} !== 2'b10) begin
            errors++;
            $display("FAIL basic_done done/match got %b want 10",
                     {TXN_DONE, ADDR_MATCH});
        end
        tick(4);
        checks++;
        if (wr_n - w0 != 2) begin
            errors++;
            $display("FAIL basic_wr_count got %0d want 2", wr_n - w0);
        end else begin
            checks++;
            if ({wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== 32'h10111122) begin
                errors++;
                $display("FAIL basic_wr_list got %h %h %h %h want 10 11 11 22",
                         wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]);
            end
        end
        checks++;
        if (done_n - d0 != 1) begin
            errors++;
            $display("FAIL basic_done_count got %0d want 1", done_n - d0);
        end
        checks++;
        if ({BYTE_CNT, TXN_BUSY} !== {8'd2, 1'b0}) begin
            errors++;
            $display("FAIL basic_cnt_busy got %h %b want 02 0", BYTE_CNT, TXN_BUSY);
        end
    endtask

    task automatic test_ignore();
        int w0 = wr_n;
        int d0 = done_n;
        auto_ack = 1'b1;
        do_start();
        send(8'hA1);
        send(8'h05);
        checks++;
        if ({TXN_BUSY, ADDR_MATCH, WR_REQ} !== 3'b100) begin
            errors++;
            $display("FAIL ignore_state busy/match/req got %b want 100",
                     {TXN_BUSY, ADDR_MATCH, WR_REQ});
        end
        send(8'h06);
        do_end();
        tick(3);
        checks++;
        if (wr_n - w0 != 0 || done_n - d0 != 0) begin
            errors++;
            $display("FAIL ignore_no_effect got writes %0d done %0d want 0 0",
                     wr_n - w0, done_n - d0);
        end
        checks++;
        if ({TXN_BUSY, BYTE_CNT} !== 9'd0) begin
            errors++;
            $display("FAIL ignore_idle busy/cnt got %b %h want 0 00",
                     TXN_BUSY, BYTE_CNT);
        end
    endtask

    task automatic test_overflow();
        int w0 = wr_n;
        int e0 = err_n;
        auto_ack = 1'b0;
        do_start();
        send(8'hA0);
        send(8'hFF);
        send(8'h01);
        send(8'h02);
        checks++;
        if ({WR_REQ, WR_ADDR, WR_DATA, TXN_ERR} !== {1'b1, 8'hFF, 8'h01, 1'b0}) begin
            errors++;
            $display("FAIL ovf_hold got %b %h %h err %b want 1 ff 01 0",
                     WR_REQ, WR_ADDR, WR_DATA, TXN_ERR);
        end
        send(8'h03);
        checks++;
        if ({TXN_ERR, BYTE_CNT} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL ovf_err err/cnt got %b %h want 1 02", TXN_ERR, BYTE_CNT);
        end
        send(8'h04);
        tick(2);
        checks++;
        if ({WR_REQ, WR_ADDR, WR_DATA} !== {1'b1, 8'hFF, 8'h01}) begin
            errors++;
            $display("FAIL ovf_stable got %b %h %h want 1 ff 01",
                     WR_REQ, WR_ADDR, WR_DATA);
        end
        do_end();
        auto_ack = 1'b1;
        tick(8);
        checks++;
        if (wr_n - w0 != 2) begin
            errors++;
            $display("FAIL ovf_wr_count got %0d want 2", wr_n - w0);
        end else begin
            checks++;
            if ({wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== 32'hFF010002) begin
                errors++;
                $display("FAIL ovf_wr_list got %h %h %h %h want ff 01 00 02",
                         wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]);
            end
        end
        checks++;
        if (err_n - e0 != 1 || TXN_BUSY !== 1'b0) begin
            errors++;
            $display("FAIL ovf_err_count got %0d busy %b want 1 0",
                     err_n - e0, TXN_BUSY);
        end
    endtask

    task automatic test_restart();
        int w0 = wr_n;
        int d0 = done_n;
        auto_ack = 1'b1;
        do_start();
        send(8'hA0);
        send(8'h20);
        send(8'h01);
        do_start();
        checks++;
        if ({ADDR_MATCH, BYTE_CNT} !== 9'd0) begin
            errors++;
            $display("FAIL restart_clear match/cnt got %b %h want 0 00",
                     ADDR_MATCH, BYTE_CNT);
        end
        send(8'hA0);
        send(8'h30);
        send(8'h02);
        do_end();
        tick(4);
        checks++;
        if (wr_n - w0 != 2) begin
            errors++;
            $display("FAIL restart_wr_count got %0d want 2", wr_n - w0);
        end else begin
            checks++;
            if ({wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]} !== 32'h20013002) begin
                errors++;
                $display("FAIL restart_wr_list got %h %h %h %h want 20 01 30 02",
                         wr_a[w0], wr_d[w0], wr_a[w0+1], wr_d[w0+1]);
            end
        end
        checks++;
        if (done_n - d0 != 1) begin
            errors++;
            $display("FAIL restart_done_count got %0d want 1", done_n - d0);
        end
    endtask

    task automatic test_reset_mid();
        logic [28:0] o;
        int w0;
        auto_ack = 1'b0;
        do_start();
        send(8'hA0);
        send(8'h77);
        send(8'h88);
        send(8'h99);
        checks++;
        if (WR_REQ !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req got %b want 1", WR_REQ);
        end
        rst = 1'b1;
        tick();
        o = {WR_REQ, WR_ADDR, WR_DATA, ADDR_MATCH, TXN_BUSY,
             TXN_DONE, TXN_ERR, BYTE_CNT};
        checks++;
        if (o !== 29'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h want 0", o);
        end
        rst = 1'b0;
        tick();
        w0 = wr_n;
        auto_ack = 1'b1;
        do_start();
        send(8'hA0);
        send(8'h00);
        send(8'h55);
        do_end();
        tick(4);
        checks++;
        if (wr_n - w0 != 1) begin
            errors++;
            $display("FAIL rstmid_wr_count got %0d want 1", wr_n - w0);
        end else begin
            checks++;
            if ({wr_a[w0], wr_d[w0]} !== 16'h0055) begin
                errors++;
                $display("FAIL rstmid_wr got %h %h want 00 55", wr_a[w0], wr_d[w0]);
            end
        end
    endtask

    task automatic test_saturate();
        int w0 = wr_n;
        int e0 = err_n;
        auto_ack = 1'b1;
        do_start();
        send(8'hA0);
        send(8'h00);
        for (int i = 0; i < 260; i++) begin
            send(8'(i));
            tick(2);
        end
        checks++;
        if (BYTE_CNT !== 8'hFF) begin
            errors++;
            $display("FAIL sat_cnt got %h want ff", BYTE_CNT);
        end
        checks++;
        if (wr_n - w0 != 260 || err_n - e0 != 0) begin
            errors++;
            $display("FAIL sat_counts got writes %0d errs %0d want 260 0",
                     wr_n - w0, err_n - e0);
        end else begin
            checks++;
            if ({wr_a[w0+255], wr_a[w0+256], wr_a[w0+259], wr_d[w0+259]} !== 32'hFF000303) begin
                errors++;
                $display("FAIL sat_wrap got %h %h %h %h want ff 00 03 03",
                         wr_a[w0+255], wr_a[w0+256], wr_a[w0+259], wr_d[w0+259]);
            end
        end
        do_end();
        tick(3);
    endtask

`ifdef IIC_TXN_TIMEOUT_EN
    task automatic test_timeout();
        int  e0;
        bit  seen = 1'b0;
        auto_ack = 1'b1;
        do_start();
        send(8'hA0);
        e0 = err_n;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (TXN_ERR === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_err got 0 want 1 within 40 cycles");
        end
        checks++;
        if ({TXN_BUSY, ADDR_MATCH} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_idle busy/match got %b want 00",
                     {TXN_BUSY, ADDR_MATCH});
        end
        tick(2);
        checks++;
        if (err_n - e0 != 1) begin
            errors++;
            $display("FAIL timeout_err_count got %0d want 1", err_n - e0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_write();
        test_ignore();
        test_overflow();
        test_restart();
        test_reset_mid();
        test_saturate();
`ifdef IIC_TXN_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_txn_ctrl.md
IIC_TXN_CTRL -- requirements
Module: iic_txn_ctrl

Interface
REQ-001 Parameter DEV_ADDR, 7'h50: 7-bit slave address this block responds to.
REQ-002 Parameter TIMEOUT_CYCLES, 4096: idle-bus watchdog limit in clk cycles; used only with the REQ-031 macro.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 IIC_START  in  1  one-cycle start/repeated-start strobe from the I2C receiver.
REQ-006 IIC_END  in  1  one-cycle stop strobe from the I2C receiver.
REQ-007 IIC_DATA  in  8  received byte, valid only with IIC_DATA_VLD.
REQ-008 IIC_DATA_VLD  in  1  one-cycle byte-valid strobe.
REQ-009 WR_REQ  out  1  register-write request to the register bank.
REQ-010 WR_ADDR  out  8  register address of the current request.
REQ-011 WR_DATA  out  8  write data of the current request.
REQ-012 WR_ACK  in  1  register-bank acceptance of WR_REQ.
REQ-013 ADDR_MATCH  out  1  level; high while the current transaction is a write addressed to DEV_ADDR.
REQ-014 TXN_BUSY  out  1  level; transaction in progress or writes still pending.
REQ-015 TXN_DONE  out  1  one-cycle pulse, matched transaction ended by stop.
REQ-016 TXN_ERR  out  1  one-cycle pulse, overflow or timeout.
REQ-017 BYTE_CNT  out  8  data bytes accepted in the current transaction; saturates at 8'hFF.

Function
REQ-018 FSM states are IDLE, ADDR, REG, DATA and IGNORE; all transitions take effect one cycle after the causing strobe.
REQ-019 IIC_START in any state: go to ADDR, clear BYTE_CNT, drop ADDR_MATCH; a simultaneous IIC_DATA_VLD byte is discarded.
REQ-020 ADDR + byte: IIC_DATA[7:1]==DEV_ADDR with IIC_DATA[0]==0 goes to REG and sets ADDR_MATCH; any other byte (read bit set, or address mismatch) goes to IGNORE.
REQ-021 REG + byte: load 8-bit register pointer with IIC_DATA and go to DATA.
REQ-022 DATA + byte: enqueue {pointer, IIC_DATA}, pointer += 1 with wrap 8'hFF->8'h00, BYTE_CNT += 1 (saturating).
REQ-023 IGNORE: all bytes discarded; only IIC_START or IIC_END leaves it.
REQ-024 IIC_END in any state: go to IDLE; TXN_DONE pulses the next cycle iff ADDR_MATCH was high; ADDR_MATCH clears; IIC_END takes priority over a simultaneous IIC_DATA_VLD.
REQ-025 Write path is a 1-entry output register plus a 1-entry pending buffer; WR_REQ asserts the cycle after enqueue when the output is empty.
REQ-026 WR_REQ, WR_ADDR and WR_DATA hold stable until WR_ACK is sampled high; WR_ACK with WR_REQ low is ignored.
REQ-027 On the WR_ACK cycle with the pending buffer full, pending moves to the output and WR_REQ stays high the next cycle; otherwise WR_REQ drops.
REQ-028 Byte in DATA while output and pending are both full: byte dropped, TXN_ERR pulses, state goes to IGNORE, queued writes still drain.
REQ-029 Queued writes always drain after IIC_END or repeated start; TXN_BUSY = (state!=IDLE) OR WR_REQ OR pending-full.

Reset
REQ-030 rst high at any clk edge, mid-transaction or mid-handshake included: state IDLE, buffers empty, pointer 0, all outputs 0 (WR_REQ, WR_ADDR, WR_DATA, ADDR_MATCH, TXN_BUSY, TXN_DONE, TXN_ERR, BYTE_CNT); outstanding writes are abandoned.

Configuration
REQ-031 With IIC_TXN_TIMEOUT_EN defined: a watchdog counter clears on every IIC_START/IIC_END/IIC_DATA_VLD and counts in ADDR, REG and DATA; on reaching TIMEOUT_CYCLES it forces IDLE, pulses TXN_ERR, clears ADDR_MATCH, and leaves queued writes draining.
REQ-032 Without IIC_TXN_TIMEOUT_EN: no watchdog logic; the FSM waits indefinitely; TXN_ERR is driven only by overflow.

Verification
REQ-033 START, 8'hA0, 8'h10, 8'h11, 8'h22, END, WR_ACK one cycle after each WR_REQ -> writes (10,11) then (11,22), ADDR_MATCH high, TXN_DONE pulse, BYTE_CNT=2.
REQ-034 START, 8'hA1, 8'h05, END -> state IGNORE, no WR_REQ, no TXN_DONE.
REQ-035 START, 8'hA0, 8'hFF, three data bytes, WR_ACK held low -> first two writes queued at addr FF and 00, third byte triggers TXN_ERR; after release, exactly 2 writes complete.
REQ-036 START, 8'hA0, 8'h20, 8'h01, repeated START, 8'hA0, 8'h30, 8'h02, END -> writes (20,01) then (30,02), one TXN_DONE pulse.
REQ-037 rst asserted while WR_REQ is high -> next cycle all outputs 0; subsequent START, 8'hA0, 8'h00, 8'h55 writes (00,55).
REQ-038 IIC_TXN_TIMEOUT_EN, TIMEOUT_CYCLES=16: START, 8'hA0, then 16 idle cycles -> TXN_ERR pulse, state IDLE, TXN_BUSY 0.
